// File: rtl/jmbl_trace_checker_if.sv
// Sample bus from the triangular-sum accumulator into its trace checker.
// There is no ready: a sample is consumed on every rising clk edge where in_valid is high.
interface jmbl_trace_checker_if #(
  parameter int W = 19
);
  logic         in_valid;
  logic [W-1:0] x;
  logic [W-1:0] y;

  modport master (output in_valid, output x, output y);
  modport slave  (input  in_valid, input  x, input  y);
endinterface

// File: rtl/jmbl_trace_checker.sv
// Shadows the accumulator recurrence x' = x + y, y' = y + 1 up to LIMIT, then
// checks the saturated hold; any divergence latches a coded, sticky error.
module jmbl_trace_checker #(
  parameter int W     = 19,
  parameter int LIMIT = 200,
  parameter int HW    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  jmbl_trace_checker_if.slave    bus,
  input  logic                   clr,
  output logic                   synced,
  output logic                   sat,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [W-1:0]           err_y,
  output logic [HW-1:0]          hold_cnt,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, SAT = 2'd2, ERROR = 2'd3} state_t;

  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  state_t        state, state_d;
  logic [W-1:0]  prev_x, prev_x_d;
  logic [W-1:0]  prev_y, prev_y_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    code_q, code_d;
  logic [W-1:0]  ey_q, ey_d;

  logic          is_start;
  logic [W-1:0]  y_step;
  logic [W-1:0]  x_sum;

  assign is_start = (bus.x == W'(1)) && (bus.y == '0);
  // Both wrap at W bits, matching the upstream adder.
  assign y_step   = prev_y + W'(1);
  assign x_sum    = prev_x + prev_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      prev_x <= '0;
      prev_y <= '0;
      hold_q <= '0;
      code_q <= 2'd0;
      ey_q   <= '0;
    end else begin
      state  <= state_d;
      prev_x <= prev_x_d;
      prev_y <= prev_y_d;
      hold_q <= hold_d;
      code_q <= code_d;
      ey_q   <= ey_d;
    end
  end

  always_comb begin
    state_d  = state;
    prev_x_d = prev_x;
    prev_y_d = prev_y;
    hold_d   = hold_q;
    code_d   = code_q;
    ey_d     = ey_q;
    if (clr) begin
      state_d  = IDLE;
      prev_x_d = '0;
      prev_y_d = '0;
      hold_d   = '0;
      code_d   = 2'd0;
      ey_d     = '0;
    end else if (bus.in_valid) begin
      case (state)
        IDLE: begin
          if (is_start) begin
            state_d  = TRACK;
            prev_x_d = W'(1);
            prev_y_d = '0;
          end
        end
        TRACK: begin
          if (is_start) begin
            prev_x_d = W'(1);
            prev_y_d = '0;
          end else if (bus.y != y_step) begin
            state_d = ERROR;
            code_d  = 2'd1;
            ey_d    = bus.y;
          end else if (bus.x != x_sum) begin
            state_d = ERROR;
            code_d  = 2'd2;
            ey_d    = bus.y;
          end else begin
            prev_x_d = bus.x;
            prev_y_d = bus.y;
            if (bus.y == LIMIT_W) begin
              state_d = SAT;
              hold_d  = '0;
            end
          end
        end
        SAT: begin
          // The invariant check outranks the step checks while saturated.
          if (is_start) begin
            state_d  = TRACK;
            prev_x_d = W'(1);
            prev_y_d = '0;
            hold_d   = '0;
          end else if (bus.x < bus.y) begin
            state_d = ERROR;
            code_d  = 2'd3;
            ey_d    = bus.y;
          end else if (bus.y != prev_y) begin
            state_d = ERROR;
            code_d  = 2'd1;
            ey_d    = bus.y;
          end else if (bus.x != prev_x) begin
            state_d = ERROR;
            code_d  = 2'd2;
            ey_d    = bus.y;
          end else if (hold_q != '1) begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    synced    = (state == TRACK) || (state == SAT);
    sat       = (state == SAT);
    err       = (state == ERROR);
    err_code  = code_q;
    err_y     = ey_q;
    hold_cnt  = hold_q;
    dbg_state = state;
  end

endmodule

// File: tb/tb_jmbl_trace_checker.sv
// Directed bench for jmbl_trace_checker: clean ramp, hold, error codes,
// clear, resync and asynchronous reset.
module tb_jmbl_trace_checker;
  localparam int W     = 19;
  localparam int LIMIT = 200;
  localparam int HW    = 16;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          synced;
  logic          sat;
  logic          err;
  logic [1:0]    err_code;
  logic [W-1:0]  err_y;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    dbg_state;

  int n_checks;
  int n_pass;

  jmbl_trace_checker_if #(.W(W)) bus ();

  jmbl_trace_checker #(.W(W), .LIMIT(LIMIT), .HW(HW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .clr       (clr),
    .synced    (synced),
    .sat       (sat),
    .err       (err),
    .err_code  (err_code),
    .err_y     (err_y),
    .hold_cnt  (hold_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // driver tasks: each returns #1 after the capturing edge
  task automatic send(input int sx, input int sy);
    bus.in_valid = 1'b1;
    bus.x = W'(sx);
    bus.y = W'(sy);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  // Start sample followed by steps up to y == upto, with a small reference model.
  task automatic ramp(input int upto);
    int mx;
    int my;
    send(1, 0);
    chk("ramp_synced_after_start", synced, 1);
    mx = 1;
    my = 0;
    for (int k = 1; k <= upto; k++) begin
      mx = mx + my;
      my = k;
      send(mx, my);
      chk("ramp_err", err, 0);
      if (k == LIMIT - 1) chk("ramp_sat_before_limit", sat, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_synced"},   synced, 0);
    chk({tag, "_sat"},      sat, 0);
    chk({tag, "_err"},      err, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_err_y"},    err_y, 0);
    chk({tag, "_hold_cnt"}, hold_cnt, 0);
  endtask

  int gaps [10] = '{0, 1, 2, 3, 0, 3, 1, 2, 0, 1};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    #1;
    check_all_zero("reset");
    chk("reset_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // non-start sample in IDLE is discarded
    send(2, 2);
    chk("idle_discard_state", dbg_state, 0);

    // clean run then hold with gaps; garbage on an invalid bus must be ignored
    ramp(LIMIT);
    chk("clean_sat", sat, 1);
    chk("clean_synced", synced, 1);
    chk("clean_hold0", hold_cnt, 0);
    bus.x = W'(5);
    bus.y = W'(77);
    idle(2);
    chk("invalid_ignored_err", err, 0);
    for (int i = 0; i < 10; i++) begin
      send(19901, 200);
      idle(gaps[i]);
    end
    chk("hold_cnt", hold_cnt, 10);
    chk("hold_err", err, 0);
    chk("hold_sat", sat, 1);

    // invariant violation while saturated: code 3 outranks code 1
    send(150, 250);
    chk("inv_err", err, 1);
    chk("inv_code", err_code, 3);
    chk("inv_err_y", err_y, 250);
    chk("inv_sat", sat, 0);
    chk("inv_synced", synced, 0);
    chk("inv_hold_frozen", hold_cnt, 10);

    // clr together with a start sample: clr wins, sample dropped
    clr = 1'b1;
    send(1, 0);
    clr = 1'b0;
    check_all_zero("clr_win");
    chk("clr_win_state", dbg_state, 0);

    // corrupt x
    send(1, 0);
    send(1, 1);
    send(2, 2);
    send(5, 3);
    chk("cx_err", err, 1);
    chk("cx_code", err_code, 2);
    chk("cx_err_y", err_y, 3);
    chk("cx_synced", synced, 0);
    send(1, 0);
    send(7, 4);
    chk("cx_sticky_err", err, 1);
    chk("cx_sticky_code", err_code, 2);
    chk("cx_sticky_err_y", err_y, 3);
    chk("cx_sticky_synced", synced, 0);

    // skipped step, then recover with clr + start
    pulse_clr();
    chk("clr_err", err, 0);
    send(1, 0);
    send(1, 1);
    send(2, 2);
    send(4, 3);
    send(10, 5);
    chk("skip_code", err_code, 1);
    chk("skip_err_y", err_y, 5);
    pulse_clr();
    send(1, 0);
    chk("skip_recover_err", err, 0);
    chk("skip_recover_synced", synced, 1);

    // resync inside TRACK
    send(1, 1);
    send(2, 2);
    send(4, 3);
    send(1, 0);
    send(1, 1);
    chk("resync_err", err, 0);
    chk("resync_synced", synced, 1);
    send(2, 2);
    chk("resync_ramp_err", err, 0);

    // asynchronous reset between edges
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    chk("async_rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;
    send(2, 2);
    chk("post_rst_idle_state", dbg_state, 0);
    chk("post_rst_synced", synced, 0);
    chk("post_rst_err", err, 0);

    // resync from SAT back to TRACK clears hold_cnt
    ramp(LIMIT);
    send(19901, 200);
    send(19901, 200);
    chk("sat_hold2", hold_cnt, 2);
    send(19901, 199);
    chk("sat_ystep_code", err_code, 1);
    chk("sat_ystep_err_y", err_y, 199);
    pulse_clr();
    ramp(LIMIT);
    send(19902, 200);
    chk("sat_xval_code", err_code, 2);
    pulse_clr();
    ramp(LIMIT);
    send(19901, 200);
    send(1, 0);
    chk("sat_resync_sat", sat, 0);
    chk("sat_resync_synced", synced, 1);
    chk("sat_resync_hold", hold_cnt, 0);
    chk("sat_resync_state", dbg_state, 1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
